// File: rtl/uart_rx_frame_checker_if.sv
// Bus between the RX oversampler/register file and the UART RX frame checker.
// Sample handshake: sampled_bit is meaningful only in a cycle where bit_valid is high; every output
// event (data_valid, start_glitch, par_err, stp_err) is a one-cycle pulse with no backpressure.
interface uart_rx_frame_checker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  EN;
  logic                  frame_start;
  logic                  bit_valid;
  logic                  sampled_bit;
  logic                  par_en;
  logic                  par_type;
  logic                  clr_cnt;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  start_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  glitch_cnt;
  logic [CNT_WIDTH-1:0]  par_err_cnt;
  logic [CNT_WIDTH-1:0]  stp_err_cnt;
  logic [2:0]            dbg_state;

  modport master (
    output EN, frame_start, bit_valid, sampled_bit, par_en, par_type, clr_cnt,
    input  data_out, data_valid, start_glitch, par_err, stp_err, busy,
    input  glitch_cnt, par_err_cnt, stp_err_cnt, dbg_state
  );

  modport slave (
    input  EN, frame_start, bit_valid, sampled_bit, par_en, par_type, clr_cnt,
    output data_out, data_valid, start_glitch, par_err, stp_err, busy,
    output glitch_cnt, par_err_cnt, stp_err_cnt, dbg_state
  );
endinterface

// File: rtl/uart_rx_frame_checker.sv
// UART RX frame checker: validates start, optional parity and stop bits of each sampled frame,
// assembles data LSB-first and keeps saturating error counters.
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input logic CLK,
  input logic RST,
  uart_rx_frame_checker_if.slave bus
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_stop_idx;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_par_acc;
  logic                  r_par_flag;
  logic                  r_stp_flag;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_start_glitch;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic [CNT_WIDTH-1:0]  r_glitch_cnt;
  logic [CNT_WIDTH-1:0]  r_par_err_cnt;
  logic [CNT_WIDTH-1:0]  r_stp_err_cnt;

  logic w_stp_flag;
  logic w_par_exp;

  // Stop flag including the current sample, so the finalize cycle sees the last stop bit.
  assign w_stp_flag = r_stp_flag | ~bus.sampled_bit;
  assign w_par_exp  = r_par_acc ^ r_par_type;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state        <= IDLE;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_stop_idx     <= 1'b0;
      r_par_en       <= 1'b0;
      r_par_type     <= 1'b0;
      r_par_acc      <= 1'b0;
      r_par_flag     <= 1'b0;
      r_stp_flag     <= 1'b0;
      r_data_out     <= '0;
      r_data_valid   <= 1'b0;
      r_start_glitch <= 1'b0;
      r_par_err      <= 1'b0;
      r_stp_err      <= 1'b0;
      r_glitch_cnt   <= '0;
      r_par_err_cnt  <= '0;
      r_stp_err_cnt  <= '0;
    end else begin
      r_data_valid   <= 1'b0;
      r_start_glitch <= 1'b0;
      r_par_err      <= 1'b0;
      r_stp_err      <= 1'b0;
      if (!bus.EN) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.frame_start) begin
              r_par_en   <= bus.par_en;
              r_par_type <= bus.par_type;
              r_shift    <= '0;
              r_bit_cnt  <= '0;
              r_stop_idx <= 1'b0;
              r_par_acc  <= 1'b0;
              r_par_flag <= 1'b0;
              r_stp_flag <= 1'b0;
              r_state    <= START;
            end
          end
          START: begin
            if (bus.bit_valid) begin
              if (bus.sampled_bit) begin
                r_start_glitch <= 1'b1;
                r_glitch_cnt   <= sat_inc(r_glitch_cnt);
                r_state        <= IDLE;
              end else begin
                r_bit_cnt <= '0;
                r_state   <= DATA;
              end
            end
          end
          DATA: begin
            if (bus.bit_valid) begin
              r_shift   <= {bus.sampled_bit, r_shift[DATA_WIDTH-1:1]};
              r_par_acc <= r_par_acc ^ bus.sampled_bit;
              if (r_bit_cnt == LAST_BIT) begin
                r_stop_idx <= 1'b0;
                r_state    <= r_par_en ? PARITY : STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
              end
            end
          end
          PARITY: begin
            if (bus.bit_valid) begin
              if (bus.sampled_bit != w_par_exp) r_par_flag <= 1'b1;
              r_stop_idx <= 1'b0;
              r_state    <= STOP;
            end
          end
          STOP: begin
            if (bus.bit_valid) begin
              r_stp_flag <= w_stp_flag;
              if (r_stop_idx == LAST_STOP) begin
                r_par_err <= r_par_flag;
                r_stp_err <= w_stp_flag;
                if (!r_par_flag && !w_stp_flag) begin
                  r_data_out   <= r_shift;
                  r_data_valid <= 1'b1;
                end
                if (r_par_flag) r_par_err_cnt <= sat_inc(r_par_err_cnt);
                if (w_stp_flag) r_stp_err_cnt <= sat_inc(r_stp_err_cnt);
                r_state <= IDLE;
              end else begin
                r_stop_idx <= 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
      // Clear is applied last so it overrides any increment on the same edge.
      if (bus.clr_cnt) begin
        r_glitch_cnt  <= '0;
        r_par_err_cnt <= '0;
        r_stp_err_cnt <= '0;
      end
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.data_valid   = r_data_valid;
  assign bus.start_glitch = r_start_glitch;
  assign bus.par_err      = r_par_err;
  assign bus.stp_err      = r_stp_err;
  assign bus.busy         = (r_state != IDLE);
  assign bus.glitch_cnt   = r_glitch_cnt;
  assign bus.par_err_cnt  = r_par_err_cnt;
  assign bus.stp_err_cnt  = r_stp_err_cnt;
  assign bus.dbg_state    = r_state;
endmodule

// File: doc/uart_rx_frame_checker.md
# uart_rx_frame_checker

Parametrised frame checker for the UART receive path. It replaces the single-bit start check with full-frame checking. It consumes the per-bit samples produced by the RX oversampler and validates the start bit (glitch rejection), the optional parity bit (even/odd, selected at run time) and 1 or 2 stop bits. It assembles the data bits LSB-first, delivers each good frame with a one-cycle valid, and keeps saturating error counters for the register file.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..9
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- CNT_WIDTH, 8, width of each error counter

Ports:
- CLK  in  1  receive clock
- RST  in  1  asynchronous, active-low reset
- EN  in  1  block enable; low forces IDLE synchronously
- frame_start  in  1  pulse from falling-edge detector; used only in IDLE
- bit_valid  in  1  one-cycle strobe: sampled_bit is valid (mid-bit)
- sampled_bit  in  1  majority-voted line sample
- par_en  in  1  parity bit present; latched at frame start
- par_type  in  1  0 = even, 1 = odd; latched at frame start
- clr_cnt  in  1  synchronous clear of all error counters
- data_out  out  DATA_WIDTH  last good frame's data
- data_valid  out  1  one-cycle pulse, new data_out
- start_glitch  out  1  one-cycle pulse, start bit sampled high
- par_err  out  1  one-cycle pulse, parity mismatch
- stp_err  out  1  one-cycle pulse, any stop bit sampled low
- busy  out  1  high whenever state is not IDLE
- glitch_cnt, par_err_cnt, stp_err_cnt  out  CNT_WIDTH each  saturating error counters

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On frame_start with EN high: latch par_en/par_type, clear shift register, bit counter and error flags, go to START.
  - bit_valid is ignored in IDLE.
- START, on bit_valid:
  - sampled_bit = 1: pulse start_glitch, increment glitch_cnt, go to IDLE.
  - sampled_bit = 0: go to DATA with bit_cnt = 0.
- DATA, on bit_valid:
  - Shift right with sampled_bit entering at the MSB, so the first data bit ends at data_out[0].
  - Accumulate XOR parity.
  - At bit_cnt = DATA_WIDTH-1, go to PARITY if latched par_en, else STOP.
- PARITY, on bit_valid:
  - Expected bit = XOR of data bits (even), or its inverse (odd).
  - Mismatch sets the internal par_flag.
  - Go to STOP with stop_idx = 0.
- STOP, on bit_valid:
  - sampled_bit = 0 sets stp_flag.
  - Every stop bit is checked even after an earlier failure.
  - At stop_idx = STOP_BITS-1, finalize and go to IDLE.
- Finalize (all outputs registered):
  - par_err = par_flag; stp_err = stp_flag.
  - If neither flag is set: load data_out and pulse data_valid.
  - Otherwise data_out holds its previous value.
  - Increment par_err_cnt and/or stp_err_cnt per flag.
  - Both errors in the same frame assert both pulses and increment both counters.
- Counters:
  - Saturate at 2^CNT_WIDTH-1; no wrap.
  - clr_cnt zeroes all three next cycle.
  - If clr_cnt coincides with an increment, the clear wins.
- frame_start outside IDLE is ignored.
- A frame_start in the same cycle as a finalize is ignored; the edge detector re-fires on the next falling edge.
- EN low in any state:
  - Next state IDLE; the partial frame is discarded.
  - No pulses are issued; counters and data_out hold.
- Latched par_en/par_type are not affected by input changes mid-frame.

## Timing
- Reset values:
  - State IDLE.
  - data_out = 0.
  - All pulses 0.
  - busy = 0.
  - All counters 0.
- busy rises the cycle after the accepted frame_start and falls the cycle after the final stop-bit bit_valid.
- start_glitch is asserted the cycle after the START bit_valid.
- data_valid, par_err and stp_err are asserted the cycle after the bit_valid that samples the last stop bit.
- Each pulse lasts exactly one cycle.
- Counters update on the same edge as their pulse.
- Back-to-back frames: frame_start may be accepted on the first cycle busy is low.
- No minimum spacing between bit_valid strobes; consecutive-cycle strobes are legal.
- Reset asserted mid-frame returns to IDLE immediately; no pulse is produced.

## Test plan
- Good frame with even parity: DATA_WIDTH=8, STOP_BITS=1, par_en=1, par_type=0. Send start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> data_valid pulse with data_out=0xA5; par_err=0; stp_err=0; counters 0.
- Parity error: same frame with par_type=1 -> par_err pulse, par_err_cnt=1, no data_valid, data_out keeps 0xA5. Sending 0x3C afterwards with odd parity bit 1 -> data_valid, data_out=0x3C.
- Start glitch and recovery: start sample 1 -> start_glitch one cycle, glitch_cnt=1, busy low the next cycle. Immediate valid frame 0x5A (par_en=0) -> data_valid, data_out=0x5A.
- Two stop bits: STOP_BITS=2, stop samples 0,1 -> stp_err pulse, stp_err_cnt=1. A frame with parity and both stop bits wrong -> par_err and stp_err in the same cycle.
- Saturation and clear: CNT_WIDTH=2, five glitch frames -> glitch_cnt holds at 3. clr_cnt in the same cycle as a sixth glitch pulse -> glitch_cnt=0.
- Abort: EN low after 4 data bits -> busy low next cycle, no pulses. Reset mid-DATA -> all outputs 0. A subsequent frame 0xFF decodes correctly.
